// File: rtl/functionality_pipe_if.sv
// Operand/result handshake bundle for functionality_pipe.
//   io_in_*      : operand pair, mode and valid/ready from the producer
//   io_acc_clear : accumulator clear, independent of the handshake
//   io_out_*     : result, overflow flag and valid/ready to the consumer
// The slave modport is the pipe's view; master is the producer/consumer side.
interface functionality_pipe_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_x;
    logic [WIDTH-1:0] io_in_y;
    logic [2:0]       io_in_mode;
    logic             io_acc_clear;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_z;
    logic             io_out_ovf;

    modport slave (
        input  io_in_valid, io_in_x, io_in_y, io_in_mode, io_acc_clear, io_out_ready,
        output io_in_ready, io_out_valid, io_out_z, io_out_ovf
    );

    modport master (
        output io_in_valid, io_in_x, io_in_y, io_in_mode, io_acc_clear, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_z, io_out_ovf
    );
endinterface

// File: rtl/functionality_pipe.sv
// Pipelined x/y -> z functionality unit with mode select, saturating
// accumulator, overflow flag and valid/ready on both sides.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   io    : functionality_pipe_if.slave handshake bundle
// The result is computed at acceptance into stage 0; the remaining stages only
// delay it. The whole pipe advances together or stalls together.
module functionality_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input logic                  clock,
    input logic                  reset,
    functionality_pipe_if.slave  io
);
    localparam int unsigned LAST = STAGES - 1;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    localparam logic [2:0] MODE_LEGACY = 3'd0;
    localparam logic [2:0] MODE_AND    = 3'd1;
    localparam logic [2:0] MODE_OR     = 3'd2;
    localparam logic [2:0] MODE_XOR    = 3'd3;
    localparam logic [2:0] MODE_SADD   = 3'd4;
    localparam logic [2:0] MODE_ACC    = 3'd5;

    logic                         advance_c;
    logic                         accept_c;
    logic [WIDTH-1:0]             acc_q;
    logic [WIDTH-1:0]             acc_base_c;
    logic [WIDTH-1:0]             acc_next_c;
    logic [WIDTH:0]               add_sum_c;
    logic [WIDTH:0]               acc_sum_c;
    logic [WIDTH-1:0]             z_c;
    logic                         ovf_c;

    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0]            vld_d;
    logic [STAGES-1:0]            ovf_q;
    logic [STAGES-1:0]            ovf_d;
    logic [STAGES-1:0][WIDTH-1:0] z_q;
    logic [STAGES-1:0][WIDTH-1:0] z_d;

    // Global stall: depends only on registered out_valid and the consumer's ready.
    assign advance_c      = !vld_q[LAST] || io.io_out_ready;
    assign accept_c       = io.io_in_valid && advance_c;
    assign io.io_in_ready = advance_c;

    // Result computation for the operand pair being accepted.
    always_comb begin
        z_c        = '0;
        ovf_c      = 1'b0;
        // Clear takes precedence over the old value when it coincides with an ACC op.
        acc_base_c = io.io_acc_clear ? '0 : acc_q;
        add_sum_c  = {1'b0, io.io_in_x} + {1'b0, io.io_in_y};
        acc_sum_c  = {1'b0, acc_base_c} + {1'b0, io.io_in_x & io.io_in_y};
        acc_next_c = acc_sum_c[WIDTH] ? ALL_ONES : acc_sum_c[WIDTH-1:0];
        case (io.io_in_mode)
            MODE_LEGACY: z_c = (io.io_in_x & io.io_in_y) | (~io.io_in_x & io.io_in_y);
            MODE_AND:    z_c = io.io_in_x & io.io_in_y;
            MODE_OR:     z_c = io.io_in_x | io.io_in_y;
            MODE_XOR:    z_c = io.io_in_x ^ io.io_in_y;
            MODE_SADD: begin
                z_c   = add_sum_c[WIDTH] ? ALL_ONES : add_sum_c[WIDTH-1:0];
                ovf_c = add_sum_c[WIDTH];
            end
            MODE_ACC: begin
                z_c   = acc_next_c;
                ovf_c = acc_sum_c[WIDTH];
            end
            default: begin
                z_c   = '0;
                ovf_c = 1'b1;
            end
        endcase
    end

    // Accumulator: updated by accepted ACC ops, cleared by io_acc_clear otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (accept_c && (io.io_in_mode == MODE_ACC)) begin
            acc_q <= acc_next_c;
        end else if (io.io_acc_clear) begin
            acc_q <= '0;
        end
    end

    // Stage inputs: stage 0 takes the new result, later stages take their predecessor.
    assign vld_d[0] = accept_c;
    assign z_d[0]   = accept_c ? z_c : '0;
    assign ovf_d[0] = accept_c && ovf_c;

    for (genvar s = 1; s < STAGES; s++) begin : g_shift
        assign vld_d[s] = vld_q[s-1];
        assign z_d[s]   = z_q[s-1];
        assign ovf_d[s] = ovf_q[s-1];
    end

    // Pipeline registers; bubbles travel with the data and are not squeezed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            z_q   <= '0;
            ovf_q <= '0;
        end else if (advance_c) begin
            vld_q <= vld_d;
            z_q   <= z_d;
            ovf_q <= ovf_d;
        end
    end

    assign io.io_out_valid = vld_q[LAST];
    assign io.io_out_z     = z_q[LAST];
    assign io.io_out_ovf   = ovf_q[LAST];
endmodule

// File: tb/tb_functionality_pipe.sv
// Directed self-checking bench for functionality_pipe (WIDTH=16, STAGES=2).
module tb_functionality_pipe;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 2;

    logic clock;
    logic reset;

    functionality_pipe_if #(.WIDTH(WIDTH)) bus ();

    functionality_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  mode;
        logic        clr;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] ez;
        logic        eovf;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int checks;
    int errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_in_valid  = 1'b0;
        bus.io_in_x      = '0;
        bus.io_in_y      = '0;
        bus.io_in_mode   = 3'd0;
        bus.io_acc_clear = 1'b0;
    endtask

    // Single op with out_ready high; checks latency, z and ovf.
    task automatic run_one(input string name, input logic [2:0] mode, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] ez, input logic eovf);
        int n;
        bus.io_in_valid = 1'b1;
        bus.io_in_mode  = mode;
        bus.io_in_x     = x;
        bus.io_in_y     = y;
        n = 0;
        step();
        idle_inputs();
        n = 1;
        while (!bus.io_out_valid && n < 10) begin
            step();
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(STAGES));
        chk({name, "_z"}, 64'(bus.io_out_z), 64'(ez));
        chk({name, "_ovf"}, 64'(bus.io_out_ovf), 64'(eovf));
        step();
    endtask

    logic [15:0] bp_x   [4];
    logic [15:0] bp_y   [4];
    logic [15:0] bp_exp [4];

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{3'd0, 1'b0, 16'h1234, 16'hABCD, 16'hABCD, 1'b0};
        vecs[1]  = '{3'd0, 1'b0, 16'hFFFF, 16'h0001, 16'h0001, 1'b0};
        vecs[2]  = '{3'd4, 1'b0, 16'hFFF0, 16'h0020, 16'hFFFF, 1'b1};
        vecs[3]  = '{3'd4, 1'b0, 16'h0010, 16'h0020, 16'h0030, 1'b0};
        vecs[4]  = '{3'd5, 1'b0, 16'hFFFF, 16'h8000, 16'h8000, 1'b0};
        vecs[5]  = '{3'd5, 1'b0, 16'hFFFF, 16'h7000, 16'hF000, 1'b0};
        vecs[6]  = '{3'd5, 1'b0, 16'hFFFF, 16'h2000, 16'hFFFF, 1'b1};
        vecs[7]  = '{3'd5, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b1};
        vecs[8]  = '{3'd5, 1'b1, 16'hFFFF, 16'h0005, 16'h0005, 1'b0};
        vecs[9]  = '{3'd1, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
        vecs[10] = '{3'd2, 1'b0, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0};
        vecs[11] = '{3'd3, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0};
        vecs[12] = '{3'd6, 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b1};
        vecs[13] = '{3'd7, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};
        vecs[14] = '{3'd5, 1'b0, 16'h0003, 16'h0001, 16'h0006, 1'b0};
        vecs[15] = '{3'd5, 1'b0, 16'hFFFF, 16'h0000, 16'h0006, 1'b0};
        vecs[16] = '{3'd1, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 1'b0};
        vecs[17] = '{3'd5, 1'b0, 16'hFFFF, 16'h0002, 16'h0002, 1'b0};

        bp_x[0] = 16'h0F0F; bp_y[0] = 16'h00FF; bp_exp[0] = 16'h0FF0;
        bp_x[1] = 16'hAAAA; bp_y[1] = 16'h5555; bp_exp[1] = 16'hFFFF;
        bp_x[2] = 16'h1234; bp_y[2] = 16'h1234; bp_exp[2] = 16'h0000;
        bp_x[3] = 16'hFFFF; bp_y[3] = 16'h0001; bp_exp[3] = 16'hFFFE;

        // Reset and idle.
        reset = 1'b0;
        idle_inputs();
        bus.io_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", 64'(bus.io_out_valid), 64'd0);
        chk("rst_z", 64'(bus.io_out_z), 64'd0);
        chk("rst_ovf", 64'(bus.io_out_ovf), 64'd0);
        reset = 1'b1;
        #1;
        chk("rst_ready", 64'(bus.io_in_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", 64'(bus.io_out_valid), 64'd0);
        end

        // Table stream: one op per cycle, each result STAGES cycles later.
        for (int i = 0; i < NV + int'(STAGES) - 1; i++) begin
            if (i < NV) begin
                bus.io_in_valid  = 1'b1;
                bus.io_in_mode   = vecs[i].mode;
                bus.io_in_x      = vecs[i].x;
                bus.io_in_y      = vecs[i].y;
                bus.io_acc_clear = vecs[i].clr;
            end else begin
                idle_inputs();
            end
            step();
            if (i >= int'(STAGES) - 1) begin
                int k;
                k = i - (int'(STAGES) - 1);
                chk($sformatf("vec%0d_valid", k), 64'(bus.io_out_valid), 64'd1);
                chk($sformatf("vec%0d_z", k), 64'(bus.io_out_z), 64'(vecs[k].ez));
                chk($sformatf("vec%0d_ovf", k), 64'(bus.io_out_ovf), 64'(vecs[k].eovf));
            end
        end
        idle_inputs();
        step();
        chk("stream_drained", 64'(bus.io_out_valid), 64'd0);

        // Reset mid-flight: two accepted ops must vanish, accumulator cleared.
        bus.io_in_valid = 1'b1;
        bus.io_in_mode  = 3'd5;
        bus.io_in_x     = 16'hFFFF;
        bus.io_in_y     = 16'h0010;
        step();
        bus.io_in_mode  = 3'd0;
        bus.io_in_y     = 16'h0042;
        step();
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.io_out_valid), 64'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_no_out", 64'(bus.io_out_valid), 64'd0);
        end
        run_one("midrst_acc", 3'd5, 16'hFFFF, 16'h0001, 16'h0001, 1'b0);
        run_one("reserved6", 3'd6, 16'hBEEF, 16'hCAFE, 16'h0000, 1'b1);

        // Backpressure: stall 5 cycles once the first result appears.
        begin
            int sent;
            int recv;
            int stall;
            logic acc_in;
            logic xfer;
            sent  = 0;
            recv  = 0;
            stall = -1;
            for (int c = 0; c < 60 && recv < 4; c++) begin
                bus.io_in_valid = (sent < 4);
                bus.io_in_mode  = 3'd3;
                bus.io_in_x     = (sent < 4) ? bp_x[sent] : 16'h0;
                bus.io_in_y     = (sent < 4) ? bp_y[sent] : 16'h0;
                if (stall < 0 && bus.io_out_valid) stall = 5;
                bus.io_out_ready = !(stall > 0);
                #1;
                if (stall > 0) begin
                    chk("bp_in_ready", 64'(bus.io_in_ready), 64'd0);
                    chk("bp_hold_valid", 64'(bus.io_out_valid), 64'd1);
                    chk("bp_hold_z", 64'(bus.io_out_z), 64'(bp_exp[recv]));
                    stall--;
                end
                acc_in = bus.io_in_valid && bus.io_in_ready;
                xfer   = bus.io_out_valid && bus.io_out_ready;
                if (xfer) begin
                    chk($sformatf("bp_res%0d_z", recv), 64'(bus.io_out_z), 64'(bp_exp[recv]));
                    recv++;
                end
                @(posedge clock);
                #1;
                if (acc_in) sent++;
            end
            chk("bp_received", 64'(recv), 64'd4);
            idle_inputs();
            bus.io_out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step();
                chk("bp_no_dup", 64'(bus.io_out_valid), 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/functionality_pipe.md
Name: functionality_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle 16-bit x/y -> z functionality unit.
- Generalised in data width and pipeline depth; adds an operation-mode select, a saturating accumulator, an overflow flag and valid/ready handshaking on both sides.
- Sits between a producer of operand pairs and a consumer of results in the basic-block datapath.
- Exercised by the same tick-driven harness flow as the other basic blocks.

Parameters:
- WIDTH, 16, operand/result width in bits; legal 4..64.
- STAGES, 2, pipeline depth = input-to-output latency in cycles; legal 1..4.

Ports:
- clock  input  1  single system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  operand pair valid.
- io_in_ready  output  1  block can accept operand pair.
- io_in_x  input  WIDTH  operand x.
- io_in_y  input  WIDTH  operand y.
- io_in_mode  input  3  operation select, sampled with operands.
- io_acc_clear  input  1  synchronous accumulator clear.
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  consumer accepts result.
- io_out_z  output  WIDTH  result.
- io_out_ovf  output  1  saturation/overflow flag for this result.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous-to-clock deassert handled upstream):
  - All stage valid bits = 0; accumulator = 0.
  - io_out_valid = 0, io_out_z = 0, io_out_ovf = 0.
  - io_in_ready = 1 while out of reset.
- Reset mid-operation: in-flight results are discarded and the accumulator is cleared. No result is emitted for operands accepted before the reset.
- Transfers: an input transfer occurs when io_in_valid && io_in_ready on a rising edge; an output transfer occurs when io_out_valid && io_out_ready.
- Pipeline and stall:
  - STAGES registers, each holding a valid bit, z and ovf.
  - Global stall: io_in_ready = !io_out_valid || io_out_ready. While stalled, all stages hold.
  - Bubbles are not squeezed.
  - No combinational path from io_in_valid to io_in_ready.
- Latency: a result is visible on io_out_* exactly STAGES cycles after acceptance when there are no stalls. Full throughput is one result per cycle.
- Computation is performed in stage 0 at acceptance; later stages only delay.
- Modes. Unsigned arithmetic, modulo WIDTH unless saturating; ovf = 0 unless stated.
  - 0 LEGACY: z = (x & y) | (~x & y), i.e. y, which is the legacy behaviour.
  - 1 AND: z = x & y.
  - 2 OR: z = x | y.
  - 3 XOR: z = x ^ y.
  - 4 SADD: sum is WIDTH+1 bits; z = carry ? all-ones : sum[WIDTH-1:0]; ovf = carry.
  - 5 ACC: the accumulator updates on acceptance as acc = sat(acc + (x & y)); z = new acc; ovf = 1 if saturation occurred this op. Once at all-ones, the accumulator stays there, with ovf = 1 on each further nonzero add.
  - 6, 7 reserved: z = 0, ovf = 1; the accumulator is not touched.
- Accumulator is updated only by accepted mode-5 operations, never while stalled.
- io_acc_clear:
  - Acts on the next edge regardless of handshake.
  - When simultaneous with an accepted mode-5 op, clear applies first: acc = sat(0 + (x & y)), and z reflects that value.
  - Results already in flight are unaffected.
- Outputs are held stable while io_out_valid && !io_out_ready.
- io_out_z and io_out_ovf are don't-care when io_out_valid = 0 (implementation zeroes them at reset).

Test Plan:
- Reset/idle (WIDTH=16, STAGES=2): hold reset low 3 cycles, then release -> io_out_valid=0, io_out_z=0, io_out_ovf=0, io_in_ready=1; no output for 10 idle cycles.
- Legacy streaming: back-to-back mode 0 with x=0x1234, y=0xABCD, then x=0xFFFF, y=0x0001, io_out_ready=1 -> z=0xABCD at cycle+2, then z=0x0001 at cycle+3, ovf=0.
- Saturating add: mode 4 with x=0xFFF0, y=0x0020 -> z=0xFFFF, ovf=1; then x=0x0010, y=0x0020 -> z=0x0030, ovf=0.
- Accumulator, with one clear: mode 5 with x=0xFFFF and y values 0x8000, 0x7000, 0x2000 -> z=0x8000, 0xF000, 0xFFFF (ovf=1 on the third). Then io_acc_clear together with mode 5, y=0x0005 -> z=0x0005.
- Backpressure: stream 4 mode-3 ops; hold io_out_ready=0 for 5 cycles after the first result -> io_in_ready=0, z/valid stable. Release -> all 4 XOR results in order, none lost or duplicated.
- Reset mid-flight and reserved mode:
  - Accept 2 ops, assert reset for 1 cycle -> no results emitted, accumulator 0.
  - Mode 6 with any operands -> z=0, ovf=1.
